// File: rtl/lin_rx_frame.sv
// LIN-style frame receiver: break detection, sync/PID/data/checksum decoding,
// and a small receive FIFO feeding the read-only RX APB register inputs.
module lin_rx_frame #(
    parameter int BIT_CLKS   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        PCLK_rx,
    input  logic        PRESETn_rx,
    input  logic        rx_i,
    input  logic        read_enable_rx,
    output logic [11:0] reg_receive_rx,
    output logic [7:0]  reg_id_rx,
    output logic [15:0] reg_data_field_rx,
    output logic [7:0]  reg_command_rx,
    output logic [7:0]  reg_status_rx
);

    localparam int CW = $clog2(14 * BIT_CLKS + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int FW = PW + 1;

    localparam logic [CW-1:0] BRK_LAST  = CW'(13 * BIT_CLKS - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CLKS / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CLKS - 1);
    localparam logic [CW-1:0] TMO_LIMIT = CW'(14 * BIT_CLKS);

    typedef enum logic [2:0] {
        ST_IDLE, ST_BREAK, ST_DELIM, ST_START, ST_DATA, ST_STOP
    } state_t;

    typedef enum logic [2:0] {
        SL_SYNC, SL_PID, SL_D0, SL_D1, SL_CKS
    } slot_t;

    logic          rx_meta, rxs;
    state_t        state;
    slot_t         slot;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic [7:0]    d0_q;
    logic [7:0]    cks_acc;
    logic          pid_err_q;
    logic [5:0]    flags;

    logic [11:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, rd_next;
    logic [FW-1:0] fill, fill_next;
    logic          ren_q;
    logic          empty_q, full_q;

    logic          stop_tick, push_req, push_ok, pop_req, overrun, fifo_full, pid_bad;
    logic [11:0]   push_entry, head_next;

    function automatic logic [7:0] eac_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[7:0] + {7'b0, s[8]};
    endfunction

    always_ff @(posedge PCLK_rx or negedge PRESETn_rx) begin
        if (!PRESETn_rx) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rxs     <= rx_meta;
        end
    end

    always_comb begin
        stop_tick  = (state == ST_STOP) && (cnt == BIT_LAST);
        push_req   = stop_tick && rxs && ((slot == SL_D0) || (slot == SL_D1));
        push_entry = {slot == SL_D1, pid_err_q, 2'b00, shift};
        pid_bad    = (shift[6] != (shift[0] ^ shift[1] ^ shift[2] ^ shift[4])) ||
                     (shift[7] != ~(shift[1] ^ shift[3] ^ shift[4] ^ shift[5]));
        fifo_full  = (fill == FW'(FIFO_DEPTH));
        pop_req    = read_enable_rx && !ren_q && (fill != '0);
        push_ok    = push_req && (!fifo_full || pop_req);
        overrun    = push_req && fifo_full && !pop_req;
        fill_next  = fill + FW'(push_ok) - FW'(pop_req);
        rd_next    = pop_req ? rd_ptr + PW'(1) : rd_ptr;
        // The new head may be the entry being written this very cycle.
        if (fill_next == '0)
            head_next = '0;
        else if (push_ok && (rd_next == wr_ptr))
            head_next = push_entry;
        else
            head_next = mem[rd_next];
    end

    always_ff @(posedge PCLK_rx) begin
        if (push_ok)
            mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge PCLK_rx or negedge PRESETn_rx) begin
        if (!PRESETn_rx) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fill           <= '0;
            ren_q          <= 1'b0;
            reg_receive_rx <= '0;
            empty_q        <= 1'b1;
            full_q         <= 1'b0;
        end else begin
            ren_q          <= read_enable_rx;
            if (push_ok)
                wr_ptr <= wr_ptr + PW'(1);
            rd_ptr         <= rd_next;
            fill           <= fill_next;
            reg_receive_rx <= head_next;
            empty_q        <= (fill_next == '0);
            full_q         <= (fill_next == FW'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge PCLK_rx or negedge PRESETn_rx) begin
        if (!PRESETn_rx) begin
            state             <= ST_IDLE;
            slot              <= SL_SYNC;
            cnt               <= '0;
            bit_idx           <= '0;
            shift             <= '0;
            d0_q              <= '0;
            cks_acc           <= '0;
            pid_err_q         <= 1'b0;
            flags             <= '0;
            reg_id_rx         <= '0;
            reg_command_rx    <= '0;
            reg_data_field_rx <= '0;
        end else begin
            if (overrun)
                flags[5] <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (!rxs) begin
                        if (cnt == BRK_LAST) begin
                            state <= ST_BREAK;
                            cnt   <= '0;
                            flags <= '0;
                            slot  <= SL_SYNC;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end else begin
                        cnt <= '0;
                    end
                end
                ST_BREAK: begin
                    if (rxs) begin
                        state <= ST_DELIM;
                        cnt   <= '0;
                    end
                end
                // Only the gaps after the sync byte are subject to the idle timeout.
                ST_DELIM: begin
                    if (!rxs) begin
                        state <= ST_START;
                        cnt   <= '0;
                    end else if (slot != SL_SYNC) begin
                        if (cnt == TMO_LIMIT) begin
                            flags[0] <= 1'b1;
                            state    <= ST_IDLE;
                            cnt      <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                ST_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (rxs) begin
                            state <= ST_DELIM;
                        end else begin
                            state   <= ST_DATA;
                            bit_idx <= '0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        shift <= {rxs, shift[7:1]};
                        if (bit_idx == 3'd7)
                            state <= ST_STOP;
                        else
                            bit_idx <= bit_idx + 3'd1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= ST_DELIM;
                        if (!rxs) begin
                            flags[0] <= 1'b1;
                            state    <= ST_IDLE;
                        end else begin
                            case (slot)
                                SL_SYNC: begin
                                    if (shift != 8'h55) begin
                                        flags[1] <= 1'b1;
                                        state    <= ST_IDLE;
                                    end else begin
                                        slot <= SL_PID;
                                    end
                                end
                                SL_PID: begin
                                    reg_id_rx      <= shift;
                                    reg_command_rx <= {2'b00, shift[5:0]};
                                    pid_err_q      <= pid_bad;
                                    if (pid_bad)
                                        flags[3] <= 1'b1;
                                    cks_acc        <= shift;
                                    slot           <= SL_D0;
                                end
                                SL_D0: begin
                                    d0_q    <= shift;
                                    cks_acc <= eac_add(cks_acc, shift);
                                    slot    <= SL_D1;
                                end
                                SL_D1: begin
                                    reg_data_field_rx <= {shift, d0_q};
                                    cks_acc           <= eac_add(cks_acc, shift);
                                    slot              <= SL_CKS;
                                end
                                SL_CKS: begin
                                    if (shift != ~cks_acc)
                                        flags[2] <= 1'b1;
                                    flags[4] <= 1'b1;
                                    state    <= ST_IDLE;
                                end
                                default: state <= ST_IDLE;
                            endcase
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign reg_status_rx = {empty_q, full_q, flags};

endmodule

// File: tb/tb_lin_rx_frame.sv
// Directed bench for lin_rx_frame: drives whole LIN frames bit by bit and
// compares the register outputs against hand-computed values.
module tb_lin_rx_frame;

    localparam int BIT_CLKS = 16;

    logic        PCLK_rx = 1'b0;
    logic        PRESETn_rx;
    logic        rx_i;
    logic        read_enable_rx;
    logic [11:0] reg_receive_rx;
    logic [7:0]  reg_id_rx;
    logic [15:0] reg_data_field_rx;
    logic [7:0]  reg_command_rx;
    logic [7:0]  reg_status_rx;

    int n_checks = 0;
    int n_pass   = 0;

    lin_rx_frame #(.BIT_CLKS(BIT_CLKS), .FIFO_DEPTH(4)) dut (
        .PCLK_rx           (PCLK_rx),
        .PRESETn_rx        (PRESETn_rx),
        .rx_i              (rx_i),
        .read_enable_rx    (read_enable_rx),
        .reg_receive_rx    (reg_receive_rx),
        .reg_id_rx         (reg_id_rx),
        .reg_data_field_rx (reg_data_field_rx),
        .reg_command_rx    (reg_command_rx),
        .reg_status_rx     (reg_status_rx)
    );

    always #5 PCLK_rx = ~PCLK_rx;

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic drive_bit(input logic b);
        rx_i = b;
        repeat (BIT_CLKS) @(negedge PCLK_rx);
    endtask

    // A pop raised here lands on the same clock edge as the mid-stop-bit push.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic pop_at_stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++)
            drive_bit(b[i]);
        rx_i = stop_bit;
        if (pop_at_stop) begin
            repeat (BIT_CLKS / 2 + 2) @(negedge PCLK_rx);
            read_enable_rx = 1'b1;
            repeat (BIT_CLKS / 2 - 2) @(negedge PCLK_rx);
            read_enable_rx = 1'b0;
        end else begin
            repeat (BIT_CLKS) @(negedge PCLK_rx);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] sync_b, input logic [7:0] pid_b,
                                 input logic [7:0] d0_b, input logic [7:0] d1_b,
                                 input logic [7:0] cks_b, input logic d0_stop,
                                 input logic [1:0] pop_mask);
        rx_i = 1'b0;
        repeat (13 * BIT_CLKS) @(negedge PCLK_rx);
        drive_bit(1'b1);
        send_byte(sync_b, 1'b1, 1'b0);
        send_byte(pid_b, 1'b1, 1'b0);
        send_byte(d0_b, d0_stop, pop_mask[0]);
        send_byte(d1_b, 1'b1, pop_mask[1]);
        send_byte(cks_b, 1'b1, 1'b0);
        rx_i = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge PCLK_rx);
    endtask

    task automatic do_pop();
        read_enable_rx = 1'b1;
        @(negedge PCLK_rx);
        read_enable_rx = 1'b0;
        repeat (2) @(negedge PCLK_rx);
    endtask

    initial begin
        PRESETn_rx     = 1'b0;
        rx_i           = 1'b1;
        read_enable_rx = 1'b0;
        repeat (3) @(negedge PCLK_rx);
        PRESETn_rx = 1'b1;
        repeat (3) @(negedge PCLK_rx);
        checkOutput("rst_receive", {4'h0, reg_receive_rx}, 16'h0000);
        checkOutput("rst_id", {8'h0, reg_id_rx}, 16'h0000);
        checkOutput("rst_data", reg_data_field_rx, 16'h0000);
        checkOutput("rst_cmd", {8'h0, reg_command_rx}, 16'h0000);
        checkOutput("rst_status", {8'h0, reg_status_rx}, 16'h0080);

        $display("[TB] good frame");
        applyStimulus(8'h55, 8'h3C, 8'h12, 8'h34, 8'h7D, 1'b1, 2'b00);
        checkOutput("good_status", {8'h0, reg_status_rx}, 16'h0010);
        checkOutput("good_id", {8'h0, reg_id_rx}, 16'h003C);
        checkOutput("good_cmd", {8'h0, reg_command_rx}, 16'h003C);
        checkOutput("good_data", reg_data_field_rx, 16'h3412);
        checkOutput("good_head0", {4'h0, reg_receive_rx}, 16'h0012);
        do_pop();
        checkOutput("good_head1", {4'h0, reg_receive_rx}, 16'h0834);
        checkOutput("good_status_pop1", {8'h0, reg_status_rx}, 16'h0010);
        do_pop();
        checkOutput("good_head_empty", {4'h0, reg_receive_rx}, 16'h0000);
        checkOutput("good_status_pop2", {8'h0, reg_status_rx}, 16'h0090);

        $display("[TB] checksum error frame");
        applyStimulus(8'h55, 8'h3C, 8'h12, 8'h34, 8'h00, 1'b1, 2'b00);
        checkOutput("cks_status", {8'h0, reg_status_rx}, 16'h0014);
        checkOutput("cks_data", reg_data_field_rx, 16'h3412);
        checkOutput("cks_head0", {4'h0, reg_receive_rx}, 16'h0012);
        do_pop();
        do_pop();
        checkOutput("cks_head_empty", {4'h0, reg_receive_rx}, 16'h0000);
        checkOutput("cks_status_empty", {8'h0, reg_status_rx}, 16'h0094);

        $display("[TB] sync error frame");
        applyStimulus(8'h54, 8'h3C, 8'h12, 8'h34, 8'h7D, 1'b1, 2'b00);
        checkOutput("sync_status", {8'h0, reg_status_rx}, 16'h0082);
        checkOutput("sync_id", {8'h0, reg_id_rx}, 16'h003C);
        checkOutput("sync_data", reg_data_field_rx, 16'h3412);
        checkOutput("sync_head", {4'h0, reg_receive_rx}, 16'h0000);

        $display("[TB] three frames without pops");
        applyStimulus(8'h55, 8'h3C, 8'h12, 8'h34, 8'h7D, 1'b1, 2'b00);
        applyStimulus(8'h55, 8'h97, 8'hAB, 8'hCD, 8'hEE, 1'b1, 2'b00);
        applyStimulus(8'h55, 8'h3D, 8'h01, 8'h02, 8'hBF, 1'b1, 2'b00);
        checkOutput("ovr_status", {8'h0, reg_status_rx}, 16'h0078);
        checkOutput("ovr_id", {8'h0, reg_id_rx}, 16'h003D);
        checkOutput("ovr_cmd", {8'h0, reg_command_rx}, 16'h003D);
        checkOutput("ovr_data", reg_data_field_rx, 16'h0201);
        checkOutput("ovr_head", {4'h0, reg_receive_rx}, 16'h0012);

        $display("[TB] pop coincident with push while full");
        applyStimulus(8'h55, 8'h3C, 8'h12, 8'h34, 8'h7D, 1'b1, 2'b11);
        checkOutput("simul_status", {8'h0, reg_status_rx}, 16'h0050);
        checkOutput("simul_data", reg_data_field_rx, 16'h3412);
        checkOutput("simul_head0", {4'h0, reg_receive_rx}, 16'h00AB);
        do_pop();
        checkOutput("simul_head1", {4'h0, reg_receive_rx}, 16'h08CD);
        do_pop();
        checkOutput("simul_head2", {4'h0, reg_receive_rx}, 16'h0012);
        do_pop();
        checkOutput("simul_head3", {4'h0, reg_receive_rx}, 16'h0834);
        do_pop();
        checkOutput("simul_head_empty", {4'h0, reg_receive_rx}, 16'h0000);
        checkOutput("simul_status_empty", {8'h0, reg_status_rx}, 16'h0090);

        $display("[TB] short low pulse in idle");
        rx_i = 1'b0;
        repeat (5 * BIT_CLKS) @(negedge PCLK_rx);
        rx_i = 1'b1;
        repeat (4 * BIT_CLKS) @(negedge PCLK_rx);
        checkOutput("pulse_status", {8'h0, reg_status_rx}, 16'h0090);
        checkOutput("pulse_id", {8'h0, reg_id_rx}, 16'h003C);

        $display("[TB] framing error on D0 stop bit");
        applyStimulus(8'h55, 8'h97, 8'h77, 8'h66, 8'h00, 1'b0, 2'b00);
        checkOutput("frm_status", {8'h0, reg_status_rx}, 16'h0081);
        checkOutput("frm_id", {8'h0, reg_id_rx}, 16'h0097);
        checkOutput("frm_cmd", {8'h0, reg_command_rx}, 16'h0017);
        checkOutput("frm_data", reg_data_field_rx, 16'h3412);
        checkOutput("frm_head", {4'h0, reg_receive_rx}, 16'h0000);

        $display("[TB] reset mid-frame");
        rx_i = 1'b0;
        repeat (13 * BIT_CLKS) @(negedge PCLK_rx);
        drive_bit(1'b1);
        send_byte(8'h55, 1'b1, 1'b0);
        rx_i = 1'b0;
        repeat (5) @(negedge PCLK_rx);
        PRESETn_rx = 1'b0;
        #1;
        checkOutput("midrst_status", {8'h0, reg_status_rx}, 16'h0080);
        checkOutput("midrst_id", {8'h0, reg_id_rx}, 16'h0000);
        checkOutput("midrst_cmd", {8'h0, reg_command_rx}, 16'h0000);
        checkOutput("midrst_data", reg_data_field_rx, 16'h0000);
        checkOutput("midrst_head", {4'h0, reg_receive_rx}, 16'h0000);
        rx_i = 1'b1;
        repeat (2) @(negedge PCLK_rx);
        PRESETn_rx = 1'b1;
        repeat (2) @(negedge PCLK_rx);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
